// File: rtl/example_mul_acc_pipe.sv
// rtl/example_mul_acc_pipe.sv - unsigned x signed multiply with optional grouped accumulation, stallable output pipeline
module example_mul_acc_pipe #(
    parameter int A_WIDTH    = 8,
    parameter int B_WIDTH    = 14,
    parameter int DOUT_WIDTH = 21,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int NUM_STAGE  = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [A_WIDTH-1:0]    din0,
    input  logic [B_WIDTH-1:0]    din1,
    input  logic                  acc_en,
    input  logic                  acc_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [CNT_WIDTH-1:0]  acc_cnt,
    output logic                  ovf
);

    localparam int PW = A_WIDTH + B_WIDTH;

    function automatic logic fits_dout(input logic [ACC_WIDTH-1:0] v);
        return (&v[ACC_WIDTH-1:DOUT_WIDTH-1]) | ~(|v[ACC_WIDTH-1:DOUT_WIDTH-1]);
    endfunction

    logic [ACC_WIDTH-1:0]  r_acc;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_sticky;
    logic [NUM_STAGE-1:0]  r_vld;
    logic [DOUT_WIDTH-1:0] r_dat [NUM_STAGE];
    logic [CNT_WIDTH-1:0]  r_pcnt [NUM_STAGE];
    logic                  r_povf [NUM_STAGE];

    logic [PW-1:0]         w_a_ext;
    logic [PW-1:0]         w_b_ext;
    logic [PW-1:0]         w_prod;
    logic [ACC_WIDTH-1:0]  w_prod_ext;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic                  w_wrap;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_stall;
    logic                  w_adv;
    logic                  w_accept;
    logic                  w_emit;
    logic [DOUT_WIDTH-1:0] w_res;
    logic [CNT_WIDTH-1:0]  w_res_cnt;
    logic                  w_res_ovf;

    // Low PW bits of an unsigned PW x PW product equal the exact two's-complement product.
    assign w_a_ext    = {{B_WIDTH{1'b0}}, din0};
    assign w_b_ext    = {{A_WIDTH{din1[B_WIDTH-1]}}, din1};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(ACC_WIDTH-PW+1){w_prod[PW-1]}}, w_prod[PW-2:0]};

    assign w_sum     = r_acc + w_prod_ext;
    assign w_wrap    = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                       (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);

    assign w_stall  = r_vld[NUM_STAGE-1] && !out_ready;
    assign w_adv    = ce && !w_stall;
    assign in_ready = w_adv;
    assign w_accept = in_valid && w_adv;
    assign w_emit   = w_accept && (!acc_en || acc_last);

    assign w_res     = acc_en ? w_sum[DOUT_WIDTH-1:0] : w_prod_ext[DOUT_WIDTH-1:0];
    assign w_res_cnt = acc_en ? w_cnt_inc : CNT_WIDTH'(1);
    assign w_res_ovf = acc_en ? (r_sticky | w_wrap | !fits_dout(w_sum)) : !fits_dout(w_prod_ext);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_vld    <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                r_dat[i]  <= '0;
                r_pcnt[i] <= '0;
                r_povf[i] <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld[0]  <= w_emit;
            r_dat[0]  <= w_emit ? w_res : '0;
            r_pcnt[0] <= w_emit ? w_res_cnt : '0;
            r_povf[0] <= w_emit && w_res_ovf;
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_dat[i]  <= r_dat[i-1];
                r_pcnt[i] <= r_pcnt[i-1];
                r_povf[i] <= r_povf[i-1];
            end
            if (w_accept && acc_en) begin
                if (acc_last) begin
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_sticky <= 1'b0;
                end else begin
                    r_acc    <= w_sum;
                    r_cnt    <= w_cnt_inc;
                    r_sticky <= r_sticky | w_wrap;
                end
            end
        end
    end

    assign out_valid = r_vld[NUM_STAGE-1];
    assign dout      = r_dat[NUM_STAGE-1];
    assign acc_cnt   = r_pcnt[NUM_STAGE-1];
    assign ovf       = r_povf[NUM_STAGE-1];

endmodule

// File: tb/tb_example_mul_acc_pipe.sv
// tb/tb_example_mul_acc_pipe.sv - directed-vector bench for example_mul_acc_pipe
module tb_example_mul_acc_pipe;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  din0 = '0;
    logic [13:0] din1 = '0;
    logic        acc_en = 1'b0;
    logic        acc_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [20:0] dout;
    logic [7:0]  acc_cnt;
    logic        ovf;

    example_mul_acc_pipe dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .acc_en(acc_en), .acc_last(acc_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .acc_cnt(acc_cnt), .ovf(ovf)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [20:0] d;
        logic [7:0]  c;
        logic        o;
        int          cyc;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(negedge ap_clk)
        if (!ap_rst && ce && out_valid && out_ready)
            q.push_back('{d: dout, c: acc_cnt, o: ovf, cyc: cyc});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [13:0] b, input logic en,
                        input logic last, output int acc_edge);
        din0 = a; din1 = b; acc_en = en; acc_last = last; in_valid = 1'b1;
        acc_edge = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge ap_clk);
            if (in_ready) begin
                acc_edge = cyc + 1;
                break;
            end
        end
        if (acc_edge < 0) check("send_timeout", 64'd0, 64'd1);
        @(posedge ap_clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input string tag);
        for (int t = 0; t < 200 && q.size() < n; t++) @(negedge ap_clk);
        repeat (8) @(negedge ap_clk);
        check({tag, "_count"}, 64'(q.size()), 64'(n));
    endtask

    task automatic check_rec(input int i, input string tag, input logic [20:0] d,
                             input logic [7:0] c, input logic o);
        rec_t r;
        r = (i < q.size()) ? q[i] : '{d: 'x, c: 'x, o: 'x, cyc: 0};
        check({tag, "_dout"}, 64'(r.d), 64'(d));
        check({tag, "_cnt"},  64'(r.c), 64'(c));
        check({tag, "_ovf"},  64'(r.o), 64'(o));
    endtask

    task automatic check_lat(input int i, input int acc_edge, input int lat, input string tag);
        int l;
        l = (i < q.size()) ? (q[i].cyc + 1 - acc_edge) : -1;
        check({tag, "_lat"}, 64'(l), 64'(lat));
    endtask

    task automatic flush();
        repeat (6) @(negedge ap_clk);
        q.delete();
        @(posedge ap_clk); #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, e1, e2, e3, ek;
        logic [13:0] ps_b [4];
        logic [20:0] ps_d [4];

        repeat (3) @(posedge ap_clk);
        #2 ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_acc_cnt", 64'(acc_cnt), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        ce = 1'b0; #1;
        check("ce0_in_ready", 64'(in_ready), 64'd0);
        ce = 1'b1;
        @(posedge ap_clk); #2;

        // Plain beat with wrapped, non-representable product
        send(8'd255, 14'h2000, 1'b0, 1'b0, e0);
        wait_q(1, "plain_wrap");
        check_rec(0, "plain_wrap", 21'h002000, 8'd1, 1'b1);
        check_lat(0, e0, 3, "plain_wrap");
        flush();

        // Back-to-back plain beats including signed boundaries
        send(8'd3,   14'd5,   1'b0, 1'b0, e0);
        send(8'd128, 14'h2000, 1'b0, 1'b0, e1);
        send(8'd128, 14'h1FFF, 1'b0, 1'b0, e2);
        send(8'd0,   14'h3FFF, 1'b0, 1'b0, e3);
        check("b2b_edges", 64'(e3 - e0), 64'd3);
        wait_q(4, "b2b");
        check_rec(0, "b2b0", 21'd15,      8'd1, 1'b0);
        check_rec(1, "b2b1", 21'h100000,  8'd1, 1'b0);
        check_rec(2, "b2b2", 21'h0FFF80,  8'd1, 1'b0);
        check_rec(3, "b2b3", 21'd0,       8'd1, 1'b0);
        check_lat(3, e3, 3, "b2b3");
        flush();

        // Accumulation group of three
        send(8'd10, 14'd100,  1'b1, 1'b0, e0);
        send(8'd20, 14'h3FCE, 1'b1, 1'b0, e1);
        send(8'd5,  14'd4,    1'b1, 1'b1, e2);
        wait_q(1, "grp3");
        check_rec(0, "grp3", 21'd20, 8'd3, 1'b0);
        check_lat(0, e2, 3, "grp3");
        flush();

        // Plain beat interleaved inside an open group
        send(8'd2, 14'd10,   1'b1, 1'b0, e0);
        send(8'd7, 14'd7,    1'b0, 1'b0, e1);
        send(8'd1, 14'h3FFB, 1'b1, 1'b1, e2);
        wait_q(2, "interleave");
        check_rec(0, "interleave_plain", 21'd49, 8'd1, 1'b0);
        check_rec(1, "interleave_grp",   21'd15, 8'd2, 1'b0);
        flush();

        // Group result outside signed 21-bit range
        send(8'd255, 14'h1FFF, 1'b1, 1'b0, e0);
        send(8'd255, 14'h1FFF, 1'b1, 1'b1, e1);
        wait_q(1, "grp_ovf");
        check_rec(0, "grp_ovf", 21'h1FBE02, 8'd2, 1'b1);
        flush();

        // Accumulator wraps both ways; final value fits, so only sticky flags it
        for (int i = 0; i < 1029; i++) send(8'd255, 14'h1FFF, 1'b1, 1'b0, e0);
        for (int i = 0; i < 1028; i++) send(8'd255, 14'h2000, 1'b1, 1'b0, e0);
        send(8'd255, 14'h2000, 1'b1, 1'b1, e0);
        send(8'd1, 14'd1, 1'b1, 1'b1, e1);
        wait_q(2, "sticky");
        check_rec(0, "sticky", 21'h1BFF05, 8'd255, 1'b1);
        check_rec(1, "sticky_clear", 21'd1, 8'd1, 1'b0);
        flush();

        // Output stall: hold out_ready low for 5 cycles after first out_valid
        ps_b = '{14'd1, 14'd2, 14'd3, 14'd4};
        ps_d = '{21'd1, 21'd4, 21'd9, 21'd16};
        out_ready = 1'b0;
        fork
            begin
                int ex;
                for (int i = 0; i < 4; i++) send(ps_b[i][7:0], ps_b[i], 1'b0, 1'b0, ex);
            end
        join_none
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge ap_clk);
        check("stall_seen_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_dout", 64'(dout), 64'd1);
            @(negedge ap_clk);
        end
        @(posedge ap_clk); #2;
        out_ready = 1'b1;
        wait fork;
        wait_q(4, "stall");
        for (int i = 0; i < 4; i++) check_rec(i, "stall_order", ps_d[i], 8'd1, 1'b0);
        flush();

        // Reset mid-group discards open group and in-flight plain beat
        send(8'd1, 14'd1, 1'b1, 1'b0, e0);
        send(8'd2, 14'd2, 1'b1, 1'b0, e1);
        send(8'd5, 14'd5, 1'b0, 1'b0, e2);
        ap_rst = 1'b1;
        @(posedge ap_clk); #2;
        ap_rst = 1'b0;
        send(8'd3, 14'd3, 1'b1, 1'b1, e3);
        wait_q(1, "rst_mid");
        check_rec(0, "rst_mid", 21'd9, 8'd1, 1'b0);
        flush();

        // Clock-enable freeze for 4 cycles with two beats in flight
        send(8'd6, 14'd7, 1'b0, 1'b0, e0);
        send(8'd2, 14'd3, 1'b0, 1'b0, e1);
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            check("ce_in_ready", 64'(in_ready), 64'd0);
            @(posedge ap_clk);
        end
        #2 ce = 1'b1;
        wait_q(2, "ce");
        check_rec(0, "ce_a", 21'd42, 8'd1, 1'b0);
        check_rec(1, "ce_b", 21'd6,  8'd1, 1'b0);
        check_lat(0, e0, 7, "ce_a");
        check_lat(1, e1, 7, "ce_b");
        ek = cyc;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
